// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives the up/enable inputs of an up_down_counter so that its
// Q sweeps up to a high limit, dwells, sweeps down to a low limit, dwells,
// and repeats for a programmed number of round trips (0 = forever).
// Optional feature macro: SWEEP_PAUSE_EN adds a 'pause' input that freezes
// the sweep (state and dwell counter) and gates the counter enable.
module sweep_ctrl #(
  parameter int BITS  = 4,
  parameter int DWELL = 2,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
`ifdef SWEEP_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [BITS-1:0]  lo_limit,
  input  logic [BITS-1:0]  hi_limit,
  input  logic [CYC_W-1:0] num_cycles,
  input  logic [BITS-1:0]  q,
  output logic             up,
  output logic             enable,
  output logic             busy,
  output logic             at_hi,
  output logic             at_lo,
  output logic             done,
  output logic             cfg_err,
  output logic [CYC_W-1:0] cycles_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DWELL_HI,
    S_DOWN,
    S_DWELL_LO
  } state_t;

  // The dwell counter is sized for the full legal DWELL range (1..255).
  localparam logic [7:0]       DWELL_LOAD = 8'(DWELL - 1);
  localparam logic [7:0]       DW_ONE     = 8'd1;
  localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_MAX    = '1;

  state_t           state;
  logic [BITS-1:0]  lo_reg;
  logic [BITS-1:0]  hi_reg;
  logic [CYC_W-1:0] num_reg;
  logic [7:0]       dwell_cnt;
  logic             hold;

`ifdef SWEEP_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  // Counter direction and enable, combinational so the counter stops exactly on the limit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    up     = 1'b1;
    enable = 1'b0;
    case (state)
      S_UP:       enable = (q != hi_reg) && !stop && !hold;
      S_DOWN: begin
        up     = 1'b0;
        enable = (q != lo_reg) && !stop && !hold;
      end
      S_DWELL_LO: up = 1'b0;
      default:    ;
    endcase
  end

  // Sweep sequencing, limit capture, dwell timing, round-trip count and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lo_reg      <= '0;
      hi_reg      <= '0;
      num_reg     <= '0;
      dwell_cnt   <= '0;
      cycles_done <= '0;
      at_hi       <= 1'b0;
      at_lo       <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      at_hi <= 1'b0;
      at_lo <= 1'b0;
      done  <= 1'b0;
      if (state == S_IDLE) begin
        // stop has priority, so a simultaneous start is dropped.
        if (start && !stop) begin
          if (lo_limit < hi_limit) begin
            lo_reg      <= lo_limit;
            hi_reg      <= hi_limit;
            num_reg     <= num_cycles;
            cycles_done <= '0;
            cfg_err     <= 1'b0;
            state       <= S_UP;
          end else begin
            cfg_err <= 1'b1;
          end
        end
      end else if (stop) begin
        state <= S_IDLE;
      end else if (!hold) begin
        case (state)
          S_UP: begin
            if (q == hi_reg) begin
              state     <= S_DWELL_HI;
              dwell_cnt <= DWELL_LOAD;
              at_hi     <= 1'b1;
            end
          end
          S_DWELL_HI: begin
            if (dwell_cnt == '0) state <= S_DOWN;
            else                 dwell_cnt <= dwell_cnt - DW_ONE;
          end
          S_DOWN: begin
            if (q == lo_reg) begin
              state     <= S_DWELL_LO;
              dwell_cnt <= DWELL_LOAD;
              at_lo     <= 1'b1;
              if (cycles_done != CYC_MAX) cycles_done <= cycles_done + CYC_ONE;
            end
          end
          S_DWELL_LO: begin
            if (dwell_cnt == '0) begin
              if ((num_reg != '0) && (cycles_done == num_reg)) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                state <= S_UP;
              end
            end else begin
              dwell_cnt <= dwell_cnt - DW_ONE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl. An up_down_counter is modelled in the
// bench and closed around the DUT; a phase-level reference model predicts
// every output on every cycle, and directed scenarios pin literal values.
module tb_sweep_ctrl;

  localparam int BITS  = 4;
  localparam int DWELL = 2;
  localparam int CYC_W = 8;

  localparam int P_IDLE = 0, P_RISE = 1, P_HOLD_HI = 2, P_FALL = 3, P_HOLD_LO = 4;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b0;
  logic             start      = 1'b0;
  logic             stop       = 1'b0;
  logic             pause      = 1'b0;
  logic [BITS-1:0]  lo_limit   = '0;
  logic [BITS-1:0]  hi_limit   = '0;
  logic [CYC_W-1:0] num_cycles = '0;
  logic [BITS-1:0]  q;
  logic             up, enable, busy, at_hi, at_lo, done, cfg_err;
  logic [CYC_W-1:0] cycles_done;

  logic            load_en  = 1'b1;
  logic [BITS-1:0] load_val = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation tallies (accumulated by the compare step).
  int en_up_cnt = 0, hold_hi_cnt = 0, hold_lo_cnt = 0;
  int at_hi_cnt = 0, at_lo_cnt = 0, done_cnt = 0;

  sweep_ctrl #(.BITS(BITS), .DWELL(DWELL), .CYC_W(CYC_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
`ifdef SWEEP_PAUSE_EN
    .pause       (pause),
`endif
    .lo_limit    (lo_limit),
    .hi_limit    (hi_limit),
    .num_cycles  (num_cycles),
    .q           (q),
    .up          (up),
    .enable      (enable),
    .busy        (busy),
    .at_hi       (at_hi),
    .at_lo       (at_lo),
    .done        (done),
    .cfg_err     (cfg_err),
    .cycles_done (cycles_done)
  );

  always #5 clk = ~clk;

  // The controlled up_down_counter; the bench can also preload it.
  always @(posedge clk) begin
    if (load_en)     q <= load_val;
    else if (enable) q <= up ? q + 4'd1 : q - 4'd1;
  end

  // Reference model: phase of the sweep plus cycles spent sitting on a limit.
  int               m_phase = P_IDLE;
  int               m_held  = 0;
  logic [BITS-1:0]  m_lo = '0, m_hi = '0;
  logic [CYC_W-1:0] m_num = '0, m_cycles = '0;
  bit               m_cfg = 0, m_at_hi = 0, m_at_lo = 0, m_done = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= P_IDLE; m_held <= 0; m_lo <= '0; m_hi <= '0; m_num <= '0;
      m_cycles <= '0; m_cfg <= 0; m_at_hi <= 0; m_at_lo <= 0; m_done <= 0;
    end else begin
      m_at_hi <= 0; m_at_lo <= 0; m_done <= 0;
      if (m_phase == P_IDLE) begin
        if (start && !stop) begin
          if (lo_limit < hi_limit) begin
            m_lo <= lo_limit; m_hi <= hi_limit; m_num <= num_cycles;
            m_cycles <= '0; m_cfg <= 0; m_phase <= P_RISE;
          end else begin
            m_cfg <= 1;
          end
        end
      end else if (stop) begin
        m_phase <= P_IDLE;
      end else if (!pause) begin
        case (m_phase)
          P_RISE: if (q == m_hi) begin
            m_phase <= P_HOLD_HI; m_held <= 1; m_at_hi <= 1;
          end
          P_HOLD_HI: begin
            m_held <= m_held + 1;
            if (m_held + 1 == DWELL + 1) m_phase <= P_FALL;
          end
          P_FALL: if (q == m_lo) begin
            m_phase <= P_HOLD_LO; m_held <= 1; m_at_lo <= 1;
            if (m_cycles != 8'hFF) m_cycles <= m_cycles + 8'd1;
          end
          P_HOLD_LO: begin
            m_held <= m_held + 1;
            if (m_held + 1 == DWELL + 1) begin
              if (m_num != 0 && m_cycles == m_num) begin
                m_phase <= P_IDLE; m_done <= 1;
              end else begin
                m_phase <= P_RISE;
              end
            end
          end
          default: m_phase <= P_IDLE;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model and update observation tallies.
  task automatic compare();
    bit exp_up, exp_en;
    exp_up = (m_phase == P_IDLE) || (m_phase == P_RISE) || (m_phase == P_HOLD_HI);
    exp_en = !stop && !pause &&
             (((m_phase == P_RISE) && (q != m_hi)) || ((m_phase == P_FALL) && (q != m_lo)));
    check("up",          32'(up),          32'(exp_up));
    check("enable",      32'(enable),      32'(exp_en));
    check("busy",        32'(busy),        32'(m_phase != P_IDLE));
    check("at_hi",       32'(at_hi),       32'(m_at_hi));
    check("at_lo",       32'(at_lo),       32'(m_at_lo));
    check("done",        32'(done),        32'(m_done));
    check("cfg_err",     32'(cfg_err),     32'(m_cfg));
    check("cycles_done", 32'(cycles_done), 32'(m_cycles));
    if (enable && up)            en_up_cnt++;
    if (busy && up && !enable)   hold_hi_cnt++;
    if (busy && !up && !enable)  hold_lo_cnt++;
    if (at_hi) at_hi_cnt++;
    if (at_lo) at_lo_cnt++;
    if (done)  done_cnt++;
  endtask

  // One clock: compare on the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int lo, input int hi, input int num);
    lo_limit   = 4'(lo);
    hi_limit   = 4'(hi);
    num_cycles = 8'(num);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic load_counter(input int v);
    load_en  = 1'b1;
    load_val = 4'(v);
    tick();
    load_en  = 1'b0;
  endtask

  // Run until the sweep returns to idle, then one more cycle to observe the done pulse.
  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(busy), 32'd0);
    tick();
  endtask

  int b_en, b_hh, b_hl, b_ah, b_al, b_dn, n;

  task automatic snap();
    b_en = en_up_cnt; b_hh = hold_hi_cnt; b_hl = hold_lo_cnt;
    b_ah = at_hi_cnt; b_al = at_lo_cnt;  b_dn = done_cnt;
  endtask

  initial begin
    // Reset with the counter preloaded to 0.
    load_en = 1'b1; load_val = '0; reset_n = 1'b0;
    tick(); tick();
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_up",      32'(up),          32'd1);
    check("rst_enable",  32'(enable),      32'd0);
    check("rst_cycles",  32'(cycles_done), 32'd0);
    reset_n = 1'b1;
    load_en = 1'b0;
    tick();

    // Basic single round trip 0 -> 12 -> 3.
    snap();
    do_start(3, 12, 1);
    wait_idle(200, "t1");
    check("t1_en_up",   32'(en_up_cnt - b_en),   32'd12);
    check("t1_hold_hi", 32'(hold_hi_cnt - b_hh), 32'd3);
    check("t1_hold_lo", 32'(hold_lo_cnt - b_hl), 32'd3);
    check("t1_at_hi",   32'(at_hi_cnt - b_ah),   32'd1);
    check("t1_at_lo",   32'(at_lo_cnt - b_al),   32'd1);
    check("t1_done",    32'(done_cnt - b_dn),    32'd1);
    check("t1_cycles",  32'(cycles_done),        32'd1);
    check("t1_q",       32'(q),                  32'd3);

    // Rejected configuration, then a valid one clears the error.
    do_start(9, 9, 1);
    check("cfg_err_set",  32'(cfg_err), 32'd1);
    check("cfg_err_busy", 32'(busy),    32'd0);
    check("cfg_err_en",   32'(enable),  32'd0);
    do_start(2, 5, 1);
    check("cfg_err_clr",  32'(cfg_err), 32'd0);
    check("cfg_ok_busy",  32'(busy),    32'd1);
    wait_idle(100, "t2");

    // Continuous mode: four round trips, no done, then stop.
    snap();
    do_start(3, 12, 0);
    n = 0;
    while (cycles_done != 8'd4 && n < 400) begin tick(); n++; end
    check("t3_reach4",  32'(cycles_done),     32'd4);
    check("t3_no_done", 32'(done_cnt - b_dn), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t3_stop_busy", 32'(busy),        32'd0);
    check("t3_kept",      32'(cycles_done), 32'd4);

    // Stop mid-UP at q=7, then resume from 7.
    load_counter(0);
    snap();
    do_start(3, 12, 1);
    n = 0;
    while (q != 4'd7 && n < 50) begin tick(); n++; end
    check("t4_reach7", 32'(q), 32'd7);
    stop = 1'b1;
    #1;
    check("t4_stop_en", 32'(enable), 32'd0);
    tick();
    stop = 1'b0;
    check("t4_idle",  32'(busy), 32'd0);
    tick();
    check("t4_q_held",  32'(q),                 32'd7);
    check("t4_no_done", 32'(done_cnt - b_dn),   32'd0);
    do_start(3, 12, 1);
    tick();
    check("t4_resume", 32'(q), 32'd8);
    wait_idle(200, "t4");

    // Start above the high limit: counter wraps 14,15,0..12.
    load_counter(14);
    snap();
    do_start(3, 12, 1);
    wait_idle(200, "t5");
    check("t5_en_up", 32'(en_up_cnt - b_en), 32'd14);
    check("t5_at_hi", 32'(at_hi_cnt - b_ah), 32'd1);
    check("t5_done",  32'(done_cnt - b_dn),  32'd1);

    // Asynchronous reset during DOWN, then a fresh sweep.
    do_start(3, 12, 0);
    n = 0;
    while (!(cycles_done == 8'd1 && busy && !up && enable) && n < 200) begin tick(); n++; end
    check("t6_in_down", 32'(busy && !up && enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy",   32'(busy),        32'd0);
    check("t6_rst_en",     32'(enable),      32'd0);
    check("t6_rst_up",     32'(up),          32'd1);
    check("t6_rst_cycles", 32'(cycles_done), 32'd0);
    check("t6_rst_pulses", 32'({at_hi, at_lo, done, cfg_err}), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    snap();
    do_start(2, 6, 2);
    wait_idle(300, "t6");
    check("t6_cycles", 32'(cycles_done),     32'd2);
    check("t6_done",   32'(done_cnt - b_dn), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 99) == 0);
      lo_limit   = 4'($urandom);
      hi_limit   = 4'($urandom);
      num_cycles = 8'($urandom_range(0, 3));
      load_en    = ($urandom_range(0, 199) == 0);
      load_val   = 4'($urandom);
`ifdef SWEEP_PAUSE_EN
      pause      = ($urandom_range(0, 9) == 0);
`endif
      tick();
    end
    start = 1'b0; stop = 1'b0; load_en = 1'b0; pause = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
- Upstream controller for up_down_counter: drives its up and enable inputs and reads back its Q.
- Sweeps the counter up from its current value to a high limit and holds for a dwell time.
- Then sweeps down to a low limit and holds again.
- Repeats for a programmed number of round trips or continuously, and reports progress to the system.

Parameters:
- BITS, 4, counter width; must match the up_down_counter BITS.
- DWELL, 2, hold cycles at each limit after arrival; legal range 1 to 255.
- CYC_W, 8, width of the round-trip count input and of cycles_done.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- stop  input  1  synchronous abort; returns to IDLE.
- lo_limit  input  BITS  low turn-around value; sampled on an accepted start.
- hi_limit  input  BITS  high turn-around value; sampled on an accepted start.
- num_cycles  input  CYC_W  round trips to run; 0 means continuous; sampled on an accepted start.
- q  input  BITS  feedback from the counter Q.
- up  output  1  counter direction: 1 = up, 0 = down.
- enable  output  1  counter enable.
- busy  output  1  high in every state except IDLE.
- at_hi  output  1  one-cycle registered pulse on entering DWELL_HI.
- at_lo  output  1  one-cycle registered pulse on entering DWELL_LO.
- done  output  1  one-cycle registered pulse when num_cycles round trips complete.
- cfg_err  output  1  sticky; set when a start is rejected for lo_limit >= hi_limit; cleared by the next accepted start.
- cycles_done  output  CYC_W  completed round trips, saturating at all-ones.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State goes to IDLE; registered limits, dwell counter and cycles_done clear to 0.
  - up=1, enable=0, busy=0, at_hi=0, at_lo=0, done=0, cfg_err=0.
- States: IDLE, UP, DWELL_HI, DOWN, DWELL_LO. All transitions occur on the rising clk edge.
- IDLE:
  - Outputs up=1, enable=0.
  - start with lo_limit < hi_limit: register the limits and num_cycles, clear cycles_done and cfg_err, go to UP.
  - start with lo_limit >= hi_limit: set cfg_err, stay in IDLE.
- UP:
  - Outputs up=1; enable = (q != hi_reg) and not stop. enable is combinational, so the counter never overshoots the limit.
  - When q == hi_reg: go to DWELL_HI, load the dwell counter with DWELL-1, pulse at_hi.
  - If q > hi_reg on entry, the counter wraps through all-ones to 0 and continues up to hi_reg. This is legal behaviour.
- DWELL_HI:
  - Outputs up=1, enable=0.
  - Decrement the dwell counter each cycle; when it reads 0, go to DOWN.
  - Total time q is held at hi_reg is DWELL+1 cycles: 1 cycle in UP plus DWELL cycles.
- DOWN:
  - Outputs up=0; enable = (q != lo_reg) and not stop.
  - When q == lo_reg: go to DWELL_LO, load DWELL-1, pulse at_lo, increment cycles_done (saturating).
- DWELL_LO:
  - Outputs up=0, enable=0.
  - When the dwell counter reads 0: if num_reg != 0 and cycles_done == num_reg, go to IDLE and pulse done; otherwise go to UP.
- stop:
  - From any non-IDLE state, go to IDLE on the next edge. enable is forced 0 in the same cycle stop is high.
  - No done pulse; cycles_done keeps its value.
- start and stop in the same cycle: stop wins; in IDLE, start is ignored.
- start while busy: ignored.
- Limit and num_cycles input changes while busy have no effect until the next accepted start.
- Output timing: up and enable are combinational from state, q and stop. busy is decoded from state. Pulses and cfg_err are registered.

Optional Feature:
- Macro: SWEEP_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit), placed after stop.
  - While pause=1: enable is forced 0, the state and dwell counter freeze, and up holds its value.
  - stop overrides pause.
- Undefined: no pause port; behaviour is identical to pause tied to 0.

Test Plan:
- BITS=4, DWELL=2, counter at 0, start with lo=3, hi=12, num=1 -> enable high for 12 cycles; q=12 held for exactly 3 cycles with at_hi pulsing once; up=0, q counts down to 3; at_lo pulses, q=3 held 3 cycles; done pulses, cycles_done=1, busy=0.
- start with lo=9, hi=9 -> cfg_err=1, busy stays 0, enable stays 0; then start with lo=2, hi=5 -> cfg_err clears, busy=1.
- num=0, lo=3, hi=12 -> q keeps oscillating between 3 and 12; after 4 round trips cycles_done=4; done never pulses.
- stop asserted mid-UP at q=7 -> enable=0 in that cycle, q stays 7, IDLE next edge, busy=0, no done; a new start resumes counting from 7.
- Counter at 14, start with lo=3, hi=12 -> q wraps 14, 15, 0, ..., 12 before DWELL_HI; at_hi pulses once.
- reset_n pulsed low during DOWN -> all outputs at reset values immediately; a start after release behaves as a fresh sweep.
